level_round_engine: RTL
=======================

// Module: level_round_engine
// PURPOSE
//  Per-level gameplay engine: the level-side end of the game controller's
//  levelXStart / levelXDone / guessesX handshake. The level is enabled by a
//  held start level from the game FSM. It generates a pseudo-random target
//  sequence, judges player guesses and counts wrong guesses. It reports
//  completion (levelDone) or failure (guesses reaching FAIL_LIMIT) back.
//  One instance per difficulty, each with different parameters.
// PARAMETERS
//  SEQ_LEN    4   correct guesses needed to clear the level (1..7)
//  KEY_W      4   guess/target width in bits (1..16)
//  FAIL_LIMIT 3   wrong-guess count that ends the level (1..7)
//  FLASH_CYC  8   cycles the result_flash feedback is held (>=1)
// PORTS
//  Clk          in   1      system clock
//  reset        in   1      synchronous, active-high
//  levelStart   in   1      held high by game FSM while this level is active
//  guess_valid  in   1      one-cycle strobe, guess_value is valid
//  guess_value  in   KEY_W  player guess
//  seed         in   16     LFSR seed, sampled on level entry
//  levelDone    out  1      high while in DONE
//  guesses      out  3      wrong-guess count, saturates at 7
//  target       out  KEY_W  current target (lfsr[KEY_W-1:0]) for the screen
//  round_idx    out  3      correct guesses so far this level
//  result_flash out  2      01 = correct, 10 = wrong, 00 = none
// BEHAVIOUR
//  - reset: state=IDLE, lfsr=0, guesses=0, round_idx=0, levelDone=0,
//    result_flash=0, flash_cnt=0. reset has priority over all other inputs.
//  - States: IDLE, LOAD, WAIT_GUESS, JUDGE, FLASH, DONE, FAIL.
//  - levelStart low in any non-IDLE state: next state is IDLE. All counters
//    clear at that edge. This is the abort path.
//  - IDLE: levelStart high -> LOAD.
//  - LOAD: lfsr<=seed, or 16'hACE1 if seed==0. Counters cleared. -> WAIT_GUESS.
//  - WAIT_GUESS: guess_valid -> guess_reg<=guess_value; -> JUDGE.
//  - JUDGE (exactly 1 cycle): compare guess_reg with lfsr[KEY_W-1:0].
//    - Match: round_idx++, lfsr advances one step, result_flash=01.
//    - Mismatch: guesses++ (saturate at 7), lfsr unchanged, result_flash=10.
//    - Then -> FLASH with flash_cnt=FLASH_CYC-1.
//  - Guess latency: strobe at edge k -> counters/result_flash update at edge
//    k+1 -> FLASH for FLASH_CYC cycles.
//  - FLASH: flash_cnt decrements. At 0: result_flash<=00.
//    - round_idx==SEQ_LEN -> DONE.
//    - else guesses>=FAIL_LIMIT -> FAIL.
//    - else -> WAIT_GUESS.
//  - guess_valid in any state other than WAIT_GUESS is ignored (not queued).
//  - LFSR step: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
//  - DONE: levelDone=1, all counters frozen until levelStart drops.
//  - FAIL: levelDone=0, guesses held (>=FAIL_LIMIT) so the game FSM sees the
//    failure. Frozen until levelStart drops.
//  - Outputs are registered except levelDone and target (decoded from
//    state / lfsr).
//  - A level re-entered after an abort restarts from LOAD with fresh counters.
// TESTING
//  1. seed=16'h0001, SEQ_LEN=4: target 1 after LOAD. Guesses 1,2,4,8 ->
//     targets 2,4,8,0 in turn, round_idx 1..4, guesses=0, then levelDone=1
//     FLASH_CYC cycles after the last JUDGE.
//  2. seed=16'h0001, guess 4'hF three times -> guesses 1,2,3,
//     result_flash=10 each time, FAIL entered, levelDone stays 0.
//     A 4th strobe leaves guesses=3.
//  3. guess_valid pulsed during FLASH and in DONE -> no counter change,
//     no state change.
//  4. levelStart dropped in the middle of FLASH -> IDLE next edge, counters=0.
//     Re-raise with seed=0 -> lfsr=16'hACE1, target=4'h1.
//  5. reset asserted in WAIT_GUESS with guess_valid high on the same edge ->
//     IDLE, every output at its reset value, guess not judged.
//  6. 8 wrong guesses with FAIL_LIMIT=7 -> guesses saturates at 7, no wrap
//     to 0.

Source files
------------

// File: rtl/level_round_engine.sv
// level_round_engine
//   Level-side end of the game controller's levelStart / levelDone / guesses
//   handshake. While levelStart is held, the engine loads an LFSR from seed,
//   shows lfsr[KEY_W-1:0] as the target, judges one player guess per round
//   and counts wrong guesses. The level ends in DONE (SEQ_LEN correct
//   guesses) or FAIL (guesses >= FAIL_LIMIT). Dropping levelStart aborts.
//
//   Ports
//     Clk, reset          clock, synchronous active-high reset
//     levelStart          held high by the game FSM while the level is active
//     guess_valid/value   one-cycle guess strobe and its value
//     seed                LFSR seed, sampled in LOAD (0 maps to 16'hACE1)
//     levelDone           high while in DONE (decoded from state)
//     guesses             wrong-guess count, saturates at 7
//     target              lfsr[KEY_W-1:0] (combinational)
//     round_idx           correct guesses so far
//     result_flash        01 correct, 10 wrong, 00 none
module level_round_engine #(
    parameter int SEQ_LEN    = 4,
    parameter int KEY_W      = 4,
    parameter int FAIL_LIMIT = 3,
    parameter int FLASH_CYC  = 8
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             levelStart,
    input  logic             guess_valid,
    input  logic [KEY_W-1:0] guess_value,
    input  logic [15:0]      seed,
    output logic             levelDone,
    output logic [2:0]       guesses,
    output logic [KEY_W-1:0] target,
    output logic [2:0]       round_idx,
    output logic [1:0]       result_flash
);

    localparam int FW = (FLASH_CYC > 1) ? $clog2(FLASH_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT_GUESS, JUDGE, FLASH, DONE, FAIL
    } state_t;

    state_t           state;
    logic [15:0]      lfsr;
    logic [KEY_W-1:0] guess_reg;
    logic [FW-1:0]    flash_cnt;

    assign levelDone = (state == DONE);
    assign target    = lfsr[KEY_W-1:0];

    always_ff @(posedge Clk) begin
        if (reset) begin
            state        <= IDLE;
            lfsr         <= 16'h0000;
            guess_reg    <= '0;
            guesses      <= 3'd0;
            round_idx    <= 3'd0;
            result_flash <= 2'b00;
            flash_cnt    <= '0;
        end else if (state != IDLE && !levelStart) begin
            // Abort: the game FSM left this level; counters start fresh next time.
            state        <= IDLE;
            guesses      <= 3'd0;
            round_idx    <= 3'd0;
            result_flash <= 2'b00;
            flash_cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (levelStart) state <= LOAD;
                LOAD: begin
                    // An all-zero LFSR would lock up, so substitute a fixed seed.
                    lfsr         <= (seed == 16'h0000) ? 16'hACE1 : seed;
                    guesses      <= 3'd0;
                    round_idx    <= 3'd0;
                    result_flash <= 2'b00;
                    flash_cnt    <= '0;
                    state        <= WAIT_GUESS;
                end
                WAIT_GUESS: if (guess_valid) begin
                    guess_reg <= guess_value;
                    state     <= JUDGE;
                end
                JUDGE: begin
                    if (guess_reg == lfsr[KEY_W-1:0]) begin
                        round_idx    <= round_idx + 3'd1;
                        lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                        result_flash <= 2'b01;
                    end else begin
                        if (guesses != 3'd7) guesses <= guesses + 3'd1;
                        result_flash <= 2'b10;
                    end
                    flash_cnt <= FW'(FLASH_CYC - 1);
                    state     <= FLASH;
                end
                FLASH: begin
                    if (flash_cnt != '0) begin
                        flash_cnt <= flash_cnt - 1'b1;
                    end else begin
                        result_flash <= 2'b00;
                        if (round_idx == 3'(SEQ_LEN))         state <= DONE;
                        else if (guesses >= 3'(FAIL_LIMIT))   state <= FAIL;
                        else                                  state <= WAIT_GUESS;
                    end
                end
                DONE:    state <= DONE;  // frozen until levelStart drops
                FAIL:    state <= FAIL;  // guesses held so the game FSM sees it
                default: state <= IDLE;
            endcase
        end
    end

endmodule
